dps_dec_seq_42: RTL and testbench
=================================

# dps_dec_seq_42

Sequenced, area-reduced DPS/FNS decoder for 42-bit 3C1S codewords. It decodes with one adder and an on-the-fly Fibonacci weight generator, processing one codeword bit per clock. It sits on the TSV receive side, where decode latency can be traded for area. Its result must equal the combinational `DPS_dec_42` value bit-for-bit.

## Interface
- `DW`, default `` `DBLEN42 ``, width of decoded data and of the accumulator.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  `codein` holds a codeword.
- `in_ready`  out  1  block can accept a codeword.
- `codein`  in  42  3C1S codeword; bit 0 is the lowest-weight bit.
- `out_valid`  out  1  `dataout` holds a decoded result.
- `out_ready`  in  1  downstream accepts the result.
- `dataout`  out  DW  decoded binary value.
- `busy`  out  1  decode in progress (state RUN).

## Operation
- Weights (FNS.vh definition): FNS01 = 1, FNS02 = 2, FNSn = FNSn-1 + FNSn-2.
- Bit k (k = 0..39) has weight FNS(k+1).
- Bit 40 has weight 2·FNS41.
- Bit 41 has weight FNS42.
- Result = Σ codein[k]·weight(k), modulo 2^DW.
- Weight generator: two registers `w_cur` and `w_prev`.
  - Loaded with w_cur = 1, w_prev = 1 on accept, so the next weight is 2.
  - After each bit: {w_prev, w_cur} <= {w_cur, w_cur + w_prev}.
  - Bit 40 adds w_cur << 1 to the accumulator. The recurrence itself is not doubled, so bit 41 still gets FNS42.
  - Weights are held DW+1 bits wide; accumulator adds are truncated to DW.
- No weight ROM and no multipliers. One adder for the accumulator, one for the weight recurrence.
- FSM states:
  - IDLE: in_ready = 1. On in_valid: latch codein into a shift register, acc = 0, bit counter cnt = 0, load weights, go to RUN.
  - RUN: each cycle, if shreg[0] then acc += weight(cnt). Shift shreg right, cnt++, advance weights. On cnt == 41, go to DONE.
  - DONE: out_valid = 1, dataout = acc (held stable). On out_ready, go to IDLE.
- in_ready = 1 only in IDLE. Codewords offered in RUN or DONE are not taken, and the source must hold them.
- No early termination on all-zero remaining bits: latency is fixed and data-independent.
- `codein` is sampled only on the accepting edge. Later changes do not affect the result.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - State goes to IDLE.
  - in_ready = 1, out_valid = 0, busy = 0, dataout = 0.
  - acc, shreg, cnt and the weight registers are cleared.
- Reset has priority over every other event, including mid-RUN or mid-DONE. Any in-flight codeword is discarded and no out_valid pulse follows.
- Accept: edge E where in_valid & in_ready.
  - busy = 1 from E through E+41 (42 RUN cycles).
  - out_valid rises at edge E+42 and stays high until the edge where out_ready = 1 is sampled.
  - Latency: 42 clocks from accept to out_valid.
- Backpressure: while out_ready = 0, dataout and out_valid are held with no change.
- Simultaneous out_ready in DONE and in_valid: the result is consumed, state goes to IDLE, and the new codeword is accepted at the next edge (in_ready is registered, not combinational from out_ready).
  - Minimum throughput: one codeword per 44 clocks.
- out_ready has no effect outside DONE; in_valid has no effect outside IDLE.
- All outputs are registered; there is no combinational path from an input to an output.

## Test plan
- Reset mid-RUN:
  - Stimulus: accept 42'h3FF_FFFF_FFFF, assert rst_n = 0 at E+20 for one cycle.
  - Required: out_valid never rises, in_ready = 1 and dataout = 0 after reset, and the next codeword 42'h1 decodes to 1.
- Single bits:
  - codein = 42'h1 → 1.
  - bit 1 → 2.
  - bit 2 → 3.
  - bit 39 → 165580141.
  - bit 40 → 535828592.
  - bit 41 → 433494437.
  - Each with out_valid exactly 42 clocks after accept.
- Mixed pattern: codein bits {0, 2, 4} = 42'h15 → 12. Bits {40, 41} → 969323029.
- Backpressure and handshake:
  - Hold out_ready = 0 for 10 cycles in DONE → dataout stable, in_ready = 0.
  - Then out_ready = 1 together with in_valid = 1 → new word accepted one edge later.
- Source hold and random scoreboard:
  - Keep in_valid = 1 with changing codein during RUN → only the accepted word is decoded.
  - 1000 random codewords with random in_valid/out_ready gaps → every result matches a Σ-weight reference model modulo 2^DW, in order, with no drops or duplicates.

Source files
------------

// File: rtl/dps_dec_seq_42.sv
// dps_dec_seq_42 - sequenced DPS/FNS decoder for 42-bit 3C1S codewords.
//
// Decodes one codeword bit per clock. It uses a single accumulator adder and
// an on-the-fly Fibonacci weight generator, so no weight ROM and no
// multipliers are needed. The fixed latency is 42 clocks from accept to
// out_valid.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   codein holds a codeword
//   in_ready   block can accept a codeword (IDLE only)
//   codein     42-bit 3C1S codeword, bit 0 has the lowest weight
//   out_valid  dataout holds a decoded result (DONE only)
//   out_ready  downstream accepts the result
//   dataout    decoded binary value, modulo 2^DW
//   busy       decode in progress (RUN)

`ifndef DBLEN42
`define DBLEN42 31
`endif

module dps_dec_seq_42 #(
  parameter int DW = `DBLEN42
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [41:0]   codein,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dataout,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic [41:0]   shreg;
  logic [5:0]    cnt;
  logic [DW:0]   w_cur;
  logic [DW:0]   w_prev;
  logic [DW-1:0] acc;
  logic [DW:0]   w_sel;
  logic [DW-1:0] addend;

  // Bit 40 carries twice FNS41. Only the addend is doubled; the recurrence
  // still runs on w_cur, so bit 41 gets FNS42.
  always_comb begin
    w_sel  = w_cur;
    if (cnt == 6'd40) begin
      w_sel = {w_cur[DW-1:0], 1'b0};
    end
    addend = w_sel[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)       state_nx = RUN;
      RUN:     if (cnt == 6'd41)   state_nx = DONE;
      DONE:    if (out_ready)      state_nx = IDLE;
      default:                     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg  <= '0;
      cnt    <= '0;
      w_cur  <= '0;
      w_prev <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg  <= codein;
            acc    <= '0;
            cnt    <= '0;
            // w_prev = 1 makes the second weight 2, matching FNS02.
            w_cur  <= (DW+1)'(1);
            w_prev <= (DW+1)'(1);
          end
        end
        RUN: begin
          if (shreg[0]) begin
            acc <= acc + addend;
          end
          shreg  <= {1'b0, shreg[41:1]};
          cnt    <= cnt + 6'd1;
          w_prev <= w_cur;
          w_cur  <= w_cur + w_prev;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign dataout   = acc;

endmodule

// File: tb/tb_dps_dec_seq_42.sv
// Directed and random bench for dps_dec_seq_42.
module tb_dps_dec_seq_42;

  localparam int DW = 31;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [41:0]   codein;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dataout;
  logic          busy;

  int checks;
  int errors;

  dps_dec_seq_42 #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .codein    (codein),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataout   (dataout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Independent reference: explicit weight table, summed per bit.
  function automatic logic [DW-1:0] model(input logic [41:0] c);
    logic [63:0] f [0:42];
    logic [63:0] s;
    f[0] = 64'd0;
    f[1] = 64'd1;
    f[2] = 64'd2;
    for (int n = 3; n <= 42; n++) f[n] = f[n-1] + f[n-2];
    s = 64'd0;
    for (int k = 0; k < 40; k++) if (c[k]) s = s + f[k+1];
    if (c[40]) s = s + 2 * f[41];
    if (c[41]) s = s + f[42];
    return s[DW-1:0];
  endfunction

  // Called 1 ns after a rising edge.
  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_timeout", 64'(n < 200), 64'd1);
  endtask

  // Returns the number of edges from accept until out_valid.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic decode(input string tag, input logic [41:0] c, input logic [DW-1:0] exp);
    int lat;
    wait_ready();
    in_valid = 1'b1;
    codein   = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    codein   = '0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_valid(lat);
    check({tag, "_latency"}, 64'(lat), 64'd42);
    check({tag, "_data"}, 64'(dataout), 64'(exp));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_consumed"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [DW-1:0] held;
    logic [41:0]   rc;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    codein    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dataout", 64'(dataout), 64'd0);
    rst_n = 1'b1;

    // Reset mid-RUN: rst_n low sampled at edge E+20.
    in_valid = 1'b1;
    codein   = 42'h3FF_FFFF_FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_dataout", 64'(dataout), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_valid", 64'(seen), 64'd0);
    decode("after_rst", 42'h1, 31'd1);

    // Single bits and mixed patterns, hand-computed values.
    decode("bit0", 42'h1, 31'd1);
    decode("bit1", 42'h2, 31'd2);
    decode("bit2", 42'h4, 31'd3);
    decode("bit39", 42'h1 << 39, 31'd165580141);
    decode("bit40", 42'h1 << 40, 31'd535828592);
    decode("bit41", 42'h1 << 41, 31'd433494437);
    decode("bits024", 42'h15, 31'd12);
    decode("bits4041", 42'h3 << 40, 31'd969323029);

    // Backpressure, then simultaneous consume + offer.
    in_valid = 1'b1;
    codein   = 42'h15;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'd42);
    held = dataout;
    check("bp_data", 64'(held), 64'd12);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (dataout !== held || !out_valid || in_ready) seen++;
    end
    check("bp_stable", 64'(seen), 64'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    codein    = 42'h1 << 40;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_idle_ready", 64'(in_ready), 64'd1);
    check("hs_idle_valid", 64'(out_valid), 64'd0);
    check("hs_idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hs_accept_busy", 64'(busy), 64'd1);
    wait_valid(lat);
    check("hs_latency", 64'(lat), 64'd42);
    check("hs_data", 64'(dataout), 64'd535828592);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Source keeps in_valid high with changing codein during RUN.
    in_valid = 1'b1;
    codein   = 42'h2;
    @(posedge clk); #1;
    seen = 0;
    while (!out_valid && seen < 100) begin
      codein = {$urandom, $urandom};
      @(posedge clk); #1;
      seen++;
    end
    in_valid = 1'b0;
    check("hold_latency", 64'(seen), 64'd42);
    check("hold_data", 64'(dataout), 64'd2);
    check("hold_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Random codewords with random gaps; one result per accepted word.
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      rc = {$urandom, $urandom};
      wait_ready();
      in_valid = 1'b1;
      codein   = rc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      codein   = {$urandom, $urandom};
      wait_valid(lat);
      check("rnd_latency", 64'(lat), 64'd42);
      check("rnd_data", 64'(dataout), 64'(model(rc)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("rnd_no_dup", 64'(out_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
